// File: rtl/memory_responder.sv
// memory_responder: strobe-driven 32-bit word RAM with WAIT_CYCLES wait states and a four-phase Done handshake.
// Optional write protection of addresses below WPROT_LIMIT is enabled by defining MEM_WPROT_EN.
module memory_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2,
  parameter int WPROT_LIMIT = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Done,
  output logic        Busy,
  output logic        Fault
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
`ifdef MEM_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt, cnt_nx;
  logic                op_wr, op_wr_nx;
  logic [ADDR_W-1:0]   addr, addr_nx;
  logic [31:0]         wdata, wdata_nx;
  logic                done_nx, busy_nx, fault_nx;
  logic                mem_we, rd_en;
  logic                below_limit, prot;
  logic [31:0]         mem [DEPTH];

  assign below_limit = 32'(addr) < $unsigned(WPROT_LIMIT);
  assign prot        = WPROT_ON && op_wr && below_limit;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_wr_nx = op_wr;
    addr_nx  = addr;
    wdata_nx = wdata;
    done_nx  = 1'b0;
    fault_nx = 1'b0;
    mem_we   = 1'b0;
    rd_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Read ^ Write) begin
          op_wr_nx = Write;
          addr_nx  = Address[ADDR_W-1:0];
          wdata_nx = DataIn;
          if (WAIT_CYCLES > 0) begin
            state_nx = S_WAIT;
            cnt_nx   = WAIT_INIT;
          end else begin
            state_nx = S_ACCESS;
          end
        end else if (Read && Write) begin
          fault_nx = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nx = S_ACCESS;
        else             cnt_nx   = cnt - 4'd1;
      end
      S_ACCESS: begin
        state_nx = S_DONE;
        done_nx  = 1'b1;
        fault_nx = prot;
        mem_we   = op_wr && !prot;
        rd_en    = !op_wr;
      end
      S_DONE: begin
        // Done (and a protection Fault) stay up until the requester drops both strobes.
        if (Read || Write) begin
          done_nx  = 1'b1;
          fault_nx = Fault;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      op_wr   <= 1'b0;
      addr    <= '0;
      wdata   <= 32'd0;
      DataOut <= 32'd0;
      Done    <= 1'b0;
      Busy    <= 1'b0;
      Fault   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      op_wr <= op_wr_nx;
      addr  <= addr_nx;
      wdata <= wdata_nx;
      Done  <= done_nx;
      Busy  <= busy_nx;
      Fault <= fault_nx;
      if (rd_en) DataOut <= mem[addr];
    end
  end

  // RAM has no reset; a reset on the ACCESS edge suppresses the write.
  always_ff @(posedge Clock) begin
    if (!Reset && mem_we) mem[addr] <= wdata;
  end
endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: table vectors, handshake corner cases, and randomized traffic vs. a RAM model.
module tb_memory_responder;
  localparam int WC_A  = 2;
  localparam int WC_B  = 0;
  localparam int LIM_A = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] ad   [2];
  logic [31:0] di   [2];
  logic [31:0] dout [2];
  logic        dn   [2];
  logic        by   [2];
  logic        ft   [2];

  int n_chk  = 0;
  int n_fail = 0;
  int nedges [2];
  logic [31:0] last_rd [2];
  bit          lr_ok   [2];
  logic [31:0] model [int];
  int          wq [$];

  memory_responder #(.ADDR_W(9), .WAIT_CYCLES(WC_A), .WPROT_LIMIT(LIM_A)) u_main (
    .Clock(clk), .Reset(rst), .Read(rd[0]), .Write(wr[0]), .Address(ad[0]), .DataIn(di[0]),
    .DataOut(dout[0]), .Done(dn[0]), .Busy(by[0]), .Fault(ft[0]));

  memory_responder #(.ADDR_W(9), .WAIT_CYCLES(WC_B), .WPROT_LIMIT(0)) u_fast (
    .Clock(clk), .Reset(rst), .Read(rd[1]), .Write(wr[1]), .Address(ad[1]), .DataIn(di[1]),
    .DataOut(dout[1]), .Done(dn[1]), .Busy(by[1]), .Fault(ft[1]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_b(input string name, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Called at a negedge with the instance idle; returns at a negedge with it idle again.
  task automatic access(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, input bit exp_f, input bit chk_rd,
                        input logic [31:0] exp_rd, output logic [31:0] got_rd);
    int n;
    n = nedges[s];
    rd[s] = !w; wr[s] = w; ad[s] = a; di[s] = d;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) begin rd[s] = 1'b0; wr[s] = 1'b0; end
      check_b("busy_in_flight", by[s], 1'b1);
      if (k < n) begin
        check_b("done_early", dn[s], 1'b0);
        check_b("fault_early", ft[s], 1'b0);
      end
    end
    check_b("done_rise", dn[s], 1'b1);
    check_b("fault_at_done", ft[s], exp_f);
    got_rd = dout[s];
    if (w) begin
      if (lr_ok[s]) check("dataout_hold_on_write", dout[s], last_rd[s]);
    end else if (chk_rd) begin
      check("read_data", dout[s], exp_rd);
      last_rd[s] = exp_rd;
      lr_ok[s] = 1'b1;
    end else begin
      lr_ok[s] = 1'b0;
    end
    if (hold) begin
      @(negedge clk);
      check_b("done_held", dn[s], 1'b1);
      check_b("busy_held", by[s], 1'b1);
      check_b("fault_held", ft[s], exp_f);
      rd[s] = 1'b0; wr[s] = 1'b0;
    end
    @(negedge clk);
    check_b("done_release", dn[s], 1'b0);
    check_b("busy_release", by[s], 1'b0);
    check_b("fault_release", ft[s], 1'b0);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] got, pre;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0085, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0085, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'h0BADF00D, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_01FF, 32'hCAFEBABE, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0010, 32'h0,        32'h0BADF00D};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0,        32'hCAFEBABE};
    vecs[6] = '{1'b1, 32'h0000_0285, 32'h11112222, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0085, 32'h0,        32'h11112222};

    nedges[0] = WC_A + 2;
    nedges[1] = WC_B + 2;
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; ad[s] = 32'd0; di[s] = 32'd0;
      last_rd[s] = 32'd0; lr_ok[s] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_dataout", dout[s], 32'd0);
      check_b("reset_done", dn[s], 1'b0);
      check_b("reset_busy", by[s], 1'b0);
      check_b("reset_fault", ft[s], 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      access(0, vecs[i].w, vecs[i].a, vecs[i].d, 1'b1, 1'b0, 1'b1, vecs[i].exp, got);
      if (vecs[i].w) begin
        model[int'(vecs[i].a[8:0])] = vecs[i].d;
        wq.push_back(int'(vecs[i].a[8:0]));
      end
    end

    // Early strobe drop: Done pulses for a single cycle.
    access(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b1, model[16], got);

    // Reset while in WAIT during a write: not committed, outputs back to reset values.
    wr[0] = 1'b1; ad[0] = 32'h0000_0010; di[0] = 32'hAAAA5555;
    @(negedge clk);
    check_b("busy_in_wait", by[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr[0] = 1'b0;
    check("rst_mid_dataout", dout[0], 32'd0);
    check_b("rst_mid_done", dn[0], 1'b0);
    check_b("rst_mid_busy", by[0], 1'b0);
    check_b("rst_mid_fault", ft[0], 1'b0);
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    lr_ok[0] = 1'b1; lr_ok[1] = 1'b1;
    @(negedge clk);
    check_b("rst_mid_no_restart", by[0], 1'b0);
    access(0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 1'b1, model[16], got);

    // Both strobes in IDLE: one-cycle Fault, no access.
    rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h0000_0085; di[0] = 32'h5A5A5A5A;
    @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b0;
    check_b("both_fault", ft[0], 1'b1);
    check_b("both_busy", by[0], 1'b0);
    check_b("both_done", dn[0], 1'b0);
    @(negedge clk);
    check_b("both_fault_clear", ft[0], 1'b0);
    access(0, 1'b0, 32'h0000_0085, 32'h0, 1'b1, 1'b0, 1'b1, model[133], got);

`ifdef MEM_WPROT_EN
    access(0, 1'b0, 32'h0000_0003, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, pre);
    access(0, 1'b1, 32'h0000_0003, 32'h1, 1'b1, 1'b1, 1'b0, 32'h0, got);
    access(0, 1'b1, 32'h0000_0003, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, got);
    access(0, 1'b0, 32'h0000_0003, 32'h0, 1'b1, 1'b0, 1'b1, pre, got);
`else
    access(0, 1'b1, 32'h0000_0003, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0, got);
    access(0, 1'b0, 32'h0000_0003, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1, got);
`endif

    // Zero wait states, address wrap.
    access(1, 1'b1, 32'h0000_0000, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h0, got);
    access(1, 1'b0, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 1'b1, 32'h12345678, got);
    access(1, 1'b0, 32'hABCD_EC00, 32'h0, 1'b0, 1'b0, 1'b1, 32'h12345678, got);

    // Randomized traffic against the word-array model.
    for (int i = 0; i < 60; i++) begin
      bit          w, hold;
      int          idx;
      logic [31:0] a, d;
      w    = ($urandom_range(0, 1) == 1) || (wq.size() == 0);
      hold = ($urandom_range(0, 3) != 0);
      if (w) idx = int'($urandom_range(LIM_A, 511));
      else   idx = wq[$urandom_range(0, wq.size() - 1)];
      a = ($urandom() & 32'hFFFF_FE00) | 32'(idx);
      d = $urandom();
      if (w) begin
        access(0, 1'b1, a, d, hold, 1'b0, 1'b0, 32'h0, got);
        model[idx] = d;
        wq.push_back(idx);
      end else begin
        access(0, 1'b0, a, 32'h0, hold, 1'b0, 1'b1, model[idx], got);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
